// File: rtl/adc_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : adc_cfg_sequencer
// Purpose  : Walks the AD9627 configuration LUT over a single-transaction SPI
//            master, with optional read-back verify and bounded retry.
// Revision : 1.0 - initial release
// ============================================================================
module adc_cfg_sequencer #(
    parameter int NUM_REGS    = 16,
    parameter int START_DELAY = 50000,
    parameter int TIMEOUT     = 4096,
    parameter int MAX_RETRY   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [9:0]  lut_index,
    input  logic [15:0] lut_reg_addr,
    input  logic [7:0]  lut_reg_data,
    input  logic        lut_verify,
    output logic        spi_wr_req,
    output logic        spi_rd_req,
    output logic [15:0] spi_addr,
    output logic [7:0]  spi_wdata,
    input  logic        spi_ack,
    input  logic [7:0]  spi_rdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [9:0]  err_index
);

    localparam int c_DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam int c_TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int c_RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [c_DLY_W-1:0] c_DLY_LAST = c_DLY_W'(START_DELAY - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);
    localparam logic [c_RTY_W-1:0] c_RTY_MAX  = c_RTY_W'(MAX_RETRY);
    localparam logic [9:0]         c_LAST_IDX = 10'(NUM_REGS - 1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WAIT_PWR = 4'd1,
        S_LOAD     = 4'd2,
        S_WRITE    = 4'd3,
        S_READ     = 4'd4,
        S_CHECK    = 4'd5,
        S_NEXT     = 4'd6,
        S_FINISH   = 4'd7,
        S_FAIL     = 4'd8
    } state_t;

    state_t             state_q,      state_d;
    logic [9:0]         lut_index_q,  lut_index_d;
    logic               spi_wr_req_q, spi_wr_req_d;
    logic               spi_rd_req_q, spi_rd_req_d;
    logic [15:0]        spi_addr_q,   spi_addr_d;
    logic [7:0]         spi_wdata_q,  spi_wdata_d;
    logic               verify_q,     verify_d;
    logic [7:0]         rdata_q,      rdata_d;
    logic [c_DLY_W-1:0] delay_cnt_q,  delay_cnt_d;
    logic [c_TMO_W-1:0] tmo_cnt_q,    tmo_cnt_d;
    logic [c_RTY_W-1:0] retry_cnt_q,  retry_cnt_d;
    logic               busy_q,       busy_d;
    logic               done_q,       done_d;
    logic               error_q,      error_d;
    logic [9:0]         err_index_q,  err_index_d;
    logic               w_retry;

    always_comb begin
        state_d      = state_q;
        lut_index_d  = lut_index_q;
        spi_wr_req_d = spi_wr_req_q;
        spi_rd_req_d = spi_rd_req_q;
        spi_addr_d   = spi_addr_q;
        spi_wdata_d  = spi_wdata_q;
        verify_d     = verify_q;
        rdata_d      = rdata_q;
        delay_cnt_d  = delay_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        retry_cnt_d  = retry_cnt_q;
        done_d       = done_q;
        error_d      = error_q;
        err_index_d  = err_index_q;
        w_retry      = 1'b0;

        case (state_q)
            S_WAIT_PWR: begin
                if (delay_cnt_q == c_DLY_LAST) begin
                    state_d     = S_LOAD;
                    lut_index_d = '0;
                end else begin
                    delay_cnt_d = delay_cnt_q + c_DLY_W'(1);
                end
            end

            S_LOAD: begin
                spi_addr_d   = lut_reg_addr;
                spi_wdata_d  = lut_reg_data;
                verify_d     = lut_verify;
                tmo_cnt_d    = '0;
                spi_wr_req_d = 1'b1;
                state_d      = S_WRITE;
            end

            S_WRITE: begin
                // A retry re-enters with the request low so the engine sees a
                // clean withdrawal before the next attempt is raised.
                if (!spi_wr_req_q) begin
                    spi_wr_req_d = 1'b1;
                    tmo_cnt_d    = '0;
                end else if (spi_ack) begin
                    spi_wr_req_d = 1'b0;
                    tmo_cnt_d    = '0;
                    if (verify_q) begin
                        spi_rd_req_d = 1'b1;
                        state_d      = S_READ;
                    end else begin
                        state_d      = S_NEXT;
                    end
                end else if (tmo_cnt_q == c_TMO_LAST) begin
                    w_retry = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + c_TMO_W'(1);
                end
            end

            S_READ: begin
                if (spi_ack) begin
                    spi_rd_req_d = 1'b0;
                    rdata_d      = spi_rdata;
                    state_d      = S_CHECK;
                end else if (tmo_cnt_q == c_TMO_LAST) begin
                    w_retry = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + c_TMO_W'(1);
                end
            end

            S_CHECK: begin
                if (rdata_q == spi_wdata_q) begin
                    state_d = S_NEXT;
                end else begin
                    w_retry = 1'b1;
                end
            end

            S_NEXT: begin
                retry_cnt_d = '0;
                if (lut_index_q == c_LAST_IDX) begin
                    state_d = S_FINISH;
                    done_d  = 1'b1;
                end else begin
                    lut_index_d = lut_index_q + 10'd1;
                    state_d     = S_LOAD;
                end
            end

            S_IDLE, S_FINISH, S_FAIL: begin
                if (start) begin
                    state_d     = S_WAIT_PWR;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    lut_index_d = '0;
                    retry_cnt_d = '0;
                    delay_cnt_d = '0;
                end
            end

            default: begin
                state_d = S_WAIT_PWR;
            end
        endcase

        if (w_retry) begin
            spi_wr_req_d = 1'b0;
            spi_rd_req_d = 1'b0;
            tmo_cnt_d    = '0;
            if (retry_cnt_q < c_RTY_MAX) begin
                retry_cnt_d = retry_cnt_q + c_RTY_W'(1);
                state_d     = S_WRITE;
            end else begin
                state_d     = S_FAIL;
                error_d     = 1'b1;
                err_index_d = lut_index_q;
            end
        end

        busy_d = !(state_d inside {S_IDLE, S_FINISH, S_FAIL});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_WAIT_PWR;
            lut_index_q  <= '0;
            spi_wr_req_q <= 1'b0;
            spi_rd_req_q <= 1'b0;
            spi_addr_q   <= '0;
            spi_wdata_q  <= '0;
            verify_q     <= 1'b0;
            rdata_q      <= '0;
            delay_cnt_q  <= '0;
            tmo_cnt_q    <= '0;
            retry_cnt_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_index_q  <= '0;
        end else begin
            state_q      <= state_d;
            lut_index_q  <= lut_index_d;
            spi_wr_req_q <= spi_wr_req_d;
            spi_rd_req_q <= spi_rd_req_d;
            spi_addr_q   <= spi_addr_d;
            spi_wdata_q  <= spi_wdata_d;
            verify_q     <= verify_d;
            rdata_q      <= rdata_d;
            delay_cnt_q  <= delay_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            retry_cnt_q  <= retry_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_index_q  <= err_index_d;
        end
    end

    assign lut_index  = lut_index_q;
    assign spi_wr_req = spi_wr_req_q;
    assign spi_rd_req = spi_rd_req_q;
    assign spi_addr   = spi_addr_q;
    assign spi_wdata  = spi_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign err_index  = err_index_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_cfg_sequencer.sv
`default_nettype none
// Bench for adc_cfg_sequencer: small LUT plus a scripted SPI responder that
// logs every transaction issued by the sequencer.
module tb_adc_cfg_sequencer;

    localparam int NUM_REGS    = 4;
    localparam int START_DELAY = 8;
    localparam int TIMEOUT     = 16;
    localparam int MAX_RETRY   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  lut_index;
    logic [15:0] lut_reg_addr;
    logic [7:0]  lut_reg_data;
    logic        lut_verify;
    logic        spi_wr_req;
    logic        spi_rd_req;
    logic [15:0] spi_addr;
    logic [7:0]  spi_wdata;
    logic        spi_ack;
    logic [7:0]  spi_rdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [9:0]  err_index;

    adc_cfg_sequencer #(
        .NUM_REGS    (NUM_REGS),
        .START_DELAY (START_DELAY),
        .TIMEOUT     (TIMEOUT),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .lut_index    (lut_index),
        .lut_reg_addr (lut_reg_addr),
        .lut_reg_data (lut_reg_data),
        .lut_verify   (lut_verify),
        .spi_wr_req   (spi_wr_req),
        .spi_rd_req   (spi_rd_req),
        .spi_addr     (spi_addr),
        .spi_wdata    (spi_wdata),
        .spi_ack      (spi_ack),
        .spi_rdata    (spi_rdata),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_index    (err_index)
    );

    always #10 clk = ~clk;

    logic [15:0] tab_addr [4] = '{16'h0000, 16'h0014, 16'h0016, 16'h00FF};
    logic [7:0]  tab_data [4] = '{8'h3C, 8'h05, 8'h80, 8'h01};

    logic [3:0] cfg_vmask;
    bit         cfg_corrupt;
    bit         cfg_drop_first;
    int         cfg_ack_dly;

    always_comb begin
        lut_reg_addr = '0;
        lut_reg_data = '0;
        lut_verify   = 1'b0;
        if (lut_index < 10'd4) begin
            lut_reg_addr = tab_addr[lut_index[1:0]];
            lut_reg_data = tab_data[lut_index[1:0]];
            lut_verify   = cfg_vmask[lut_index[1:0]];
        end
    end

    int          n_wr, n_rd, addr_err, both_seen;
    logic [31:0] wseq, rseq;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic clear_logs();
        n_wr = 0; n_rd = 0; addr_err = 0; both_seen = 0;
        wseq = '0; rseq = '0;
    endtask

    // Responder: ack cfg_ack_dly cycles after a request rises; index of each
    // new transaction is packed one nibble per transaction into wseq/rseq.
    initial begin
        logic [1:0] kind, prev_kind;
        int         age;
        bit         supp;
        spi_ack = 1'b0; spi_rdata = '0; prev_kind = 2'b00; age = 0; supp = 1'b0;
        forever begin
            @(negedge clk);
            kind = {spi_rd_req, spi_wr_req};
            if (kind == 2'b11) both_seen++;
            if (kind == 2'b00) begin
                age = 0; supp = 1'b0; spi_ack = 1'b0;
            end else begin
                if (kind != prev_kind) begin
                    age  = 1;
                    supp = 1'b0;
                    if (lut_index >= 10'd4) addr_err++;
                    if (kind[0]) begin
                        if (cfg_drop_first && n_wr == 0) supp = 1'b1;
                        if (n_wr < 8) wseq = wseq | (32'(lut_index[3:0]) << (4 * n_wr));
                        if (spi_addr != tab_addr[lut_index[1:0]] ||
                            spi_wdata != tab_data[lut_index[1:0]]) addr_err++;
                        n_wr++;
                    end else begin
                        if (n_rd < 8) rseq = rseq | (32'(lut_index[3:0]) << (4 * n_rd));
                        if (spi_addr != tab_addr[lut_index[1:0]]) addr_err++;
                        n_rd++;
                    end
                end else begin
                    age++;
                end
                if (age == cfg_ack_dly && !supp) begin
                    spi_ack   = 1'b1;
                    spi_rdata = spi_wdata ^ {7'd0, cfg_corrupt};
                end else begin
                    spi_ack   = 1'b0;
                end
            end
            prev_kind = kind;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        clear_logs();
        rst = 1'b0;
    endtask

    task automatic wait_end(input string nm);
        int c;
        c = 0;
        while (!(done || error) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        n_tests++;
        if (!(done || error)) begin
            n_fail++;
            $display("FAIL %s_complete: done=%0b error=%0b, expected completion within 3000 cycles",
                     nm, done, error);
        end
    endtask

    task automatic wait_wr(input string nm, input logic [9:0] idx);
        int c;
        c = 0;
        while (!(spi_wr_req && lut_index == idx) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        n_tests++;
        if (!(spi_wr_req && lut_index == idx)) begin
            n_fail++;
            $display("FAIL %s_reach: no write on entry %0d within 3000 cycles (lut_index=%0d)",
                     nm, idx, lut_index);
        end
    endtask

    typedef struct {
        string       name;
        logic [3:0]  vmask;
        bit          corrupt;
        bit          drop_first;
        int          ack_dly;
        logic        exp_done;
        logic        exp_error;
        logic [9:0]  exp_eidx;
        int          exp_wr;
        int          exp_rd;
        logic [31:0] exp_wseq;
        logic [31:0] exp_rseq;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c;
        vecs[0] = '{"plain",      4'b0000, 1'b0, 1'b0, 3,  1'b1, 1'b0, 10'd0, 4, 0, 32'h3210,  32'h0};
        vecs[1] = '{"verify2",    4'b0100, 1'b0, 1'b0, 3,  1'b1, 1'b0, 10'd0, 4, 1, 32'h3210,  32'h2};
        vecs[2] = '{"corrupt1",   4'b0010, 1'b1, 1'b0, 3,  1'b0, 1'b1, 10'd1, 4, 3, 32'h1110,  32'h111};
        vecs[3] = '{"tmo_first",  4'b0000, 1'b0, 1'b1, 3,  1'b1, 1'b0, 10'd0, 5, 0, 32'h32100, 32'h0};
        vecs[4] = '{"ack_at_tmo", 4'b0000, 1'b0, 1'b0, 16, 1'b1, 1'b0, 10'd0, 4, 0, 32'h3210,  32'h0};
        vecs[5] = '{"no_ack",     4'b0000, 1'b0, 1'b0, 17, 1'b0, 1'b1, 10'd0, 3, 0, 32'h0,     32'h0};

        rst = 1'b1; start = 1'b0;
        cfg_vmask = '0; cfg_corrupt = 1'b0; cfg_drop_first = 1'b0; cfg_ack_dly = 3;
        clear_logs();
        repeat (2) @(negedge clk);

        chk("rst_wr_req",    32'(spi_wr_req), 32'h0);
        chk("rst_rd_req",    32'(spi_rd_req), 32'h0);
        chk("rst_busy",      32'(busy),       32'h0);
        chk("rst_done",      32'(done),       32'h0);
        chk("rst_error",     32'(error),      32'h0);
        chk("rst_lut_index", 32'(lut_index),  32'h0);
        chk("rst_addr_data", {8'h0, spi_addr, spi_wdata}, 32'h0);
        chk("rst_err_index", 32'(err_index),  32'h0);

        for (int i = 0; i < 6; i++) begin
            cfg_vmask      = vecs[i].vmask;
            cfg_corrupt    = vecs[i].corrupt;
            cfg_drop_first = vecs[i].drop_first;
            cfg_ack_dly    = vecs[i].ack_dly;
            do_reset();
            wait_end(vecs[i].name);
            repeat (2) @(negedge clk);
            chk({vecs[i].name, "_done"},      32'(done),      32'(vecs[i].exp_done));
            chk({vecs[i].name, "_error"},     32'(error),     32'(vecs[i].exp_error));
            chk({vecs[i].name, "_err_index"}, 32'(err_index), 32'(vecs[i].exp_eidx));
            chk({vecs[i].name, "_busy"},      32'(busy),      32'h0);
            chk({vecs[i].name, "_n_wr"},      32'(n_wr),      32'(vecs[i].exp_wr));
            chk({vecs[i].name, "_n_rd"},      32'(n_rd),      32'(vecs[i].exp_rd));
            chk({vecs[i].name, "_wseq"},      wseq,           vecs[i].exp_wseq);
            chk({vecs[i].name, "_rseq"},      rseq,           vecs[i].exp_rseq);
            chk({vecs[i].name, "_addr_data"}, 32'(addr_err),  32'h0);
            chk({vecs[i].name, "_both_req"},  32'(both_seen), 32'h0);
        end

        // Reset while writing entry 3: request drops, full restart after delay.
        cfg_vmask = '0; cfg_corrupt = 1'b0; cfg_drop_first = 1'b0; cfg_ack_dly = 3;
        do_reset();
        wait_wr("midrst", 10'd3);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_wr_req",    32'(spi_wr_req), 32'h0);
        chk("midrst_lut_index", 32'(lut_index),  32'h0);
        chk("midrst_busy",      32'(busy),       32'h0);
        clear_logs();
        rst = 1'b0;
        c = 0;
        while (!spi_wr_req && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("midrst_restart_cycles", 32'(c),         32'(START_DELAY + 1));
        chk("midrst_restart_index",  32'(lut_index), 32'h0);
        chk("midrst_restart_busy",   32'(busy),      32'h1);

        // start while busy must not disturb the running sequence.
        wait_wr("start_busy", 10'd2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end("start_busy");
        chk("start_busy_done", 32'(done), 32'h1);
        chk("start_busy_n_wr", 32'(n_wr), 32'd4);
        chk("start_busy_wseq", wseq,      32'h3210);

        // start after an error clears it and reruns from entry 0.
        cfg_vmask = 4'b0010; cfg_corrupt = 1'b1;
        do_reset();
        wait_end("rerun_err");
        chk("rerun_error_set", 32'(error), 32'h1);
        cfg_vmask = '0; cfg_corrupt = 1'b0;
        clear_logs();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rerun_error_clr", 32'(error),     32'h0);
        chk("rerun_busy",      32'(busy),      32'h1);
        chk("rerun_lut_index", 32'(lut_index), 32'h0);
        wait_end("rerun");
        chk("rerun_done",  32'(done),  32'h1);
        chk("rerun_error", 32'(error), 32'h0);
        chk("rerun_n_wr",  32'(n_wr),  32'd4);
        chk("rerun_wseq",  wseq,       32'h3210);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_cfg_sequencer.md
Name: adc_cfg_sequencer

Overview:
Sequences AD9627 register configuration over a shared single-transaction SPI engine: walks the configuration LUT, issues a write per entry, optionally reads back and compares, retries on mismatch or timeout. Sits between lut_config and a transaction-level SPI master on the 50 MHz domain. Provides global configuration status (busy/done/error) to the capture logic.

Parameters:
NUM_REGS, 16, number of LUT entries sequenced (index 0..NUM_REGS-1)
START_DELAY, 50000, cycles waited after reset/start before first transaction (1 ms at 50 MHz)
TIMEOUT, 4096, cycles allowed from req assertion to ack before the attempt counts as failed
MAX_RETRY, 3, retries per entry after the first attempt

Ports:
clk  in  1  50 MHz configuration clock
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle pulse: rerun full configuration; ignored while busy
lut_index  out  10  LUT address presented to lut_config
lut_reg_addr  in  16  register address from LUT (combinational on lut_index)
lut_reg_data  in  8  register value from LUT
lut_verify  in  1  1 = read back and compare this entry after write
spi_wr_req  out  1  write transaction request, level, held until spi_ack
spi_rd_req  out  1  read transaction request, level, held until spi_ack
spi_addr  out  16  transaction register address
spi_wdata  out  8  transaction write data
spi_ack  in  1  single-cycle completion pulse from SPI engine
spi_rdata  in  8  read data, valid in the spi_ack cycle of a read
busy  out  1  configuration in progress
done  out  1  level: all entries configured successfully
error  out  1  level: an entry exhausted its retries
err_index  out  10  index of failing entry, valid while error=1

Behaviour:
- Reset values: lut_index=0, spi_wr_req=0, spi_rd_req=0, spi_addr=0, spi_wdata=0, busy=0, done=0, error=0, err_index=0; state=WAIT_PWR (configuration auto-starts on reset release), delay counter=0, retry counter=0.
- Reset asserted mid-transaction: all requests drop on the next edge; sequence restarts from WAIT_PWR, index 0. SPI engine must tolerate request withdrawal.
- States: IDLE, WAIT_PWR, LOAD, WRITE, READ, CHECK, NEXT, FINISH, FAIL.
- WAIT_PWR: busy=1; count START_DELAY cycles, then LOAD with lut_index=0.
- LOAD: one cycle; capture lut_reg_addr/lut_reg_data/lut_verify into spi_addr/spi_wdata/verify flag (LUT settles during this cycle from lut_index set on previous edge) -> WRITE.
- WRITE: spi_wr_req=1; timeout counter increments each cycle. spi_ack -> spi_wr_req=0 next edge; go READ if verify flag else NEXT. Counter reaching TIMEOUT-1 without ack -> retry.
- READ: spi_rd_req=1, same timeout rule. spi_ack -> register spi_rdata, go CHECK.
- CHECK: one cycle; rdata==spi_wdata -> NEXT, else retry.
- Retry: drop req; if retry counter < MAX_RETRY, increment it and return to WRITE (same entry); else FAIL.
- NEXT: clear retry counter; if lut_index==NUM_REGS-1 -> FINISH, else lut_index+1 -> LOAD.
- FINISH: busy=0, done=1, hold; -> IDLE semantics (start accepted).
- FAIL: busy=0, error=1, err_index=lut_index; start accepted.
- start in IDLE/FINISH/FAIL: clears done/error, lut_index=0, retry=0, -> WAIT_PWR. start while busy ignored.
- spi_ack outside WRITE/READ ignored. ack in the same cycle the timeout expires counts as success.
- Never assert spi_wr_req and spi_rd_req together. One outstanding transaction at most.
- Total latency success, no verify, ack after k cycles each: START_DELAY + NUM_REGS*(k+3) cycles, ±1 per entry.

Test Plan:
(bench: NUM_REGS=4, START_DELAY=8, TIMEOUT=16, MAX_RETRY=2)
- Release rst, model acks 3 cycles after req, verify=0 -> 4 writes in index order, addrs/data match LUT, done=1, busy=0, no spi_rd_req seen.
- Entry 2 verify=1, model echoes written data -> write then read of entry 2 only, done=1.
- Entry 1 verify=1, model returns data XOR 0x01 always -> exactly 3 write+read pairs on entry 1, then error=1, err_index=1, entries 2-3 never issued.
- No ack on entry 0 first attempt, normal afterwards -> req drops after 16 cycles, re-issued, sequence completes with done=1.
- rst pulsed while spi_wr_req=1 on entry 3 -> req low next edge, 8-cycle wait, restart at index 0.
- start during busy -> ignored; start after error -> error=0, full rerun from index 0.
